// File: rtl/sdr_rd_capture.sv
`default_nettype none
// ============================================================================
//  Module      : sdr_rd_capture
//  Description : SDRAM read-data capture. Registers DQ, tracks READ and
//                BURST TERMINATE commands through a CAS-latency delay line,
//                and delivers burst words with valid/last/tag qualifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdr_rd_capture #(
    parameter int DSIZE     = 16,
    parameter int CAS_LAT   = 3,
    parameter int BURST_LEN = 8,
    parameter int TAG_W     = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             RD_CMD,
    input  logic [TAG_W-1:0] RD_TAG,
    input  logic             BURST_TERM,
    input  logic [DSIZE-1:0] DQIN,
    output logic [DSIZE-1:0] RD_DATA,
    output logic             RD_VALID,
    output logic             RD_LAST,
    output logic [TAG_W-1:0] RD_TAGO,
    output logic             RD_BUSY
);

    localparam int                 c_CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BURST_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // Delay line: stage 0 holds the command seen on the previous cycle;
    // stage CAS_LAT lines up with the captured DQ word.
    logic [CAS_LAT:0]   r_start;
    logic [CAS_LAT:0]   r_term;
    logic [TAG_W-1:0]   r_tag [0:CAS_LAT];

    logic [DSIZE-1:0]   r_data;
    logic [c_CNT_W-1:0] r_cnt;
    logic [TAG_W-1:0]   r_tago;
    logic               r_busy;

    logic               w_tap_start;
    logic               w_tap_term;
    logic               w_la_start;
    logic               w_la_term;
    logic               w_valid;
    logic               w_last;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [TAG_W-1:0]   w_tago;
    logic               w_busy_next;

    // Shift command qualifiers; a READ in the same cycle masks a terminate.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_start <= '0;
            r_term  <= '0;
            for (int i = 0; i <= CAS_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_start  <= {r_start[CAS_LAT-1:0], RD_CMD};
            r_term   <= {r_term[CAS_LAT-1:0], BURST_TERM & ~RD_CMD};
            r_tag[0] <= RD_TAG;
            for (int i = 1; i <= CAS_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // Capture the DQ pins on every edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_data <= '0;
        end else begin
            r_data <= DQIN;
        end
    end

    // Burst tracking from the output tap and the look-ahead tap.
    always_comb begin
        w_tap_start = r_start[CAS_LAT];
        w_tap_term  = r_term[CAS_LAT];
        w_la_start  = r_start[CAS_LAT-1];
        w_la_term   = r_term[CAS_LAT-1];
        w_valid     = 1'b0;
        w_cnt_next  = '0;
        w_tago      = r_tago;
        if (w_tap_start) begin
            w_valid    = 1'b1;
            w_cnt_next = c_CNT_LOAD;
            w_tago     = r_tag[CAS_LAT];
        end else if (w_tap_term) begin
            w_valid    = 1'b0;
            w_cnt_next = '0;
        end else if (r_cnt != '0) begin
            w_valid    = 1'b1;
            w_cnt_next = r_cnt - c_CNT_ONE;
        end
        // Final word: natural end of burst, or a READ/terminate arriving next.
        w_last      = w_valid & ((w_cnt_next == '0) | w_la_start | w_la_term);
        w_busy_next = (|r_start) | (w_valid & ~w_last);
    end

    // Counter, tag and busy registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt  <= '0;
            r_tago <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tago <= w_tago;
            r_busy <= w_busy_next;
        end
    end

    assign RD_DATA  = r_data;
    assign RD_VALID = w_valid;
    assign RD_LAST  = w_last;
    assign RD_TAGO  = w_tago;
    assign RD_BUSY  = r_busy;

endmodule
`default_nettype wire
